// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-client SPI bus arbiter.
// Client 0 is the inertial sensor, client 1 the A2D interface.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        XFER,
        GAP
    } arb_state_t;

    localparam int NUM_CLIENTS = 2;
    localparam int INERT_IDX   = 0;
    localparam int A2D_IDX     = 1;

endpackage

// File: rtl/SPI_mnrch.sv
// SPI_mnrch: 16-bit SPI master, SCLK = clk/32, idle high.
// Ports: wrt/wt_data start a transfer; done pulses with rd_data valid;
// SS_n, SCLK, MOSI, MISO are the serial pins.
module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    logic [4:0]  sclk_div;
    logic [15:0] shft_reg;
    logic [3:0]  bit_cnt;
    logic        active;
    logic        first;
    logic        miso_smpl;

    // MISO is sampled one clk before SCLK rises; the shift happens
    // on the fall. The first fall after SS_n drops is a front porch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_div  <= 5'b11000;
            shft_reg  <= '0;
            bit_cnt   <= '0;
            active    <= 1'b0;
            first     <= 1'b0;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wrt && !active) begin
                active   <= 1'b1;
                first    <= 1'b1;
                SS_n     <= 1'b0;
                sclk_div <= 5'b11000;
                shft_reg <= wt_data;
                bit_cnt  <= '0;
            end else if (active) begin
                sclk_div <= sclk_div + 5'd1;
                if (sclk_div == 5'b01111)
                    miso_smpl <= MISO;
                if (sclk_div == 5'b11111) begin
                    if (first) begin
                        first <= 1'b0;
                    end else begin
                        shft_reg <= {shft_reg[14:0], miso_smpl};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            active   <= 1'b0;
                            SS_n     <= 1'b1;
                            done     <= 1'b1;
                            sclk_div <= 5'b11000;
                        end
                    end
                end
            end
        end
    end

    assign SCLK    = sclk_div[4];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;

endmodule

// File: rtl/spi_bus_arb.sv
// spi_bus_arb: shares one SPI_mnrch between two clients with a
// one-deep queue per client, round-robin grant and an SS_n-high gap.
// Ports: wrt/cmd0/cmd1 requests; done/rd_data completion; busy and
// ovr status; SS_n[1:0]/SCLK/MOSI/MISO[1:0] to the two slaves.
module spi_bus_arb
    import spi_arb_pkg::*;
#(
    parameter int unsigned GAP_CYC = 32,
    parameter bit          RR_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CLIENTS-1:0] wrt,
    input  logic [15:0]            cmd0,
    input  logic [15:0]            cmd1,
    output logic [NUM_CLIENTS-1:0] done,
    output logic [15:0]            rd_data,
    output logic [NUM_CLIENTS-1:0] busy,
    output logic [NUM_CLIENTS-1:0] ovr,
    output logic [NUM_CLIENTS-1:0] SS_n,
    output logic                   SCLK,
    output logic                   MOSI,
    input  logic [NUM_CLIENTS-1:0] MISO
);

    arb_state_t state;
    logic [NUM_CLIENTS-1:0] pend;
    logic                   grant;
    logic                   last;
    logic [7:0]             gap_cnt;
    logic [15:0]            creg0;
    logic [15:0]            creg1;

    logic                   core_wrt;
    logic [15:0]            core_wdata;
    logic                   core_done;
    logic [15:0]            core_rd;
    logic                   core_ss_n;
    logic                   core_miso;

    logic                   pick;
    logic [NUM_CLIENTS-1:0] pick_oh;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [NUM_CLIENTS-1:0] inflight;
    logic [NUM_CLIENTS-1:0] accept;
    logic [NUM_CLIENTS-1:0] pend_clr;
    logic                   sel_on;

    // On a tie, round-robin serves whoever was not served last.
    always_comb begin
        pick = 1'b0;
        if (pend == 2'b11)
            pick = RR_EN ? ~last : 1'b0;
        else
            pick = pend[1] & ~pend[0];
    end

    assign pick_oh  = pick  ? 2'b10 : 2'b01;
    assign grant_oh = grant ? 2'b10 : 2'b01;

    // A client is in flight only until its core done; during GAP it
    // may already queue its next command.
    assign inflight = (state == LAUNCH || state == XFER) ? grant_oh : 2'b00;
    assign accept   = wrt & ~pend & ~inflight;
    assign pend_clr = (state == IDLE && |pend) ? pick_oh : 2'b00;
    assign busy     = pend | inflight;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend    <= '0;
            grant   <= 1'b0;
            last    <= 1'b1;
            gap_cnt <= '0;
            creg0   <= '0;
            creg1   <= '0;
            done    <= '0;
            ovr     <= '0;
            rd_data <= '0;
        end else begin
            done <= '0;
            ovr  <= wrt & ~accept;
            pend <= (pend & ~pend_clr) | accept;
            if (accept[INERT_IDX])
                creg0 <= cmd0;
            if (accept[A2D_IDX])
                creg1 <= cmd1;
            unique case (state)
                IDLE: begin
                    if (|pend) begin
                        grant <= pick;
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    state <= XFER;
                end
                XFER: begin
                    if (core_done) begin
                        rd_data <= core_rd;
                        done    <= grant_oh;
                        last    <= grant;
                        gap_cnt <= 8'(GAP_CYC);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_wrt   = (state == LAUNCH);
    assign core_wdata = (grant == 1'(A2D_IDX)) ? creg1 : creg0;
    assign core_miso  = MISO[grant];

    // Only the granted slave ever sees the core select.
    assign sel_on  = (state != IDLE);
    assign SS_n[0] = (sel_on && !grant) ? core_ss_n : 1'b1;
    assign SS_n[1] = (sel_on &&  grant) ? core_ss_n : 1'b1;

    SPI_mnrch u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (core_wrt),
        .wt_data (core_wdata),
        .MISO    (core_miso),
        .done    (core_done),
        .rd_data (core_rd),
        .SS_n    (core_ss_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

endmodule
